// File: rtl/uartprobe_ng.sv
// rtl/uartprobe_ng.sv - UART probe command engine: GPIO banks and single-beat AXI master
module uartprobe_ng #(
    parameter int                      GPIO_BANKS        = 2,
    parameter int                      AXI_DW            = 32,
    parameter logic [32*GPIO_BANKS-1:0] GPO_ON_RESET     = '0,
    parameter logic [31:0]             AXI_ADDR_ON_RESET = 32'h0,
    parameter int                      TIMEOUT           = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic [32*GPIO_BANKS-1:0]  gpo,
    input  logic [32*GPIO_BANKS-1:0]  gpi,
    output logic [31:0]               m_axi_araddr,
    output logic [2:0]                m_axi_arsize,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DW-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [31:0]               m_axi_awaddr,
    output logic [2:0]                m_axi_awsize,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_DW-1:0]         m_axi_wdata,
    output logic [AXI_DW/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);
    localparam int          NB      = AXI_DW / 8;
    localparam int          LNB     = $clog2(NB);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RX_ARG, AXI_AR, AXI_R, AXI_AWW, AXI_B, TX} state_t;

    state_t                    state;
    logic [2:0]                op;
    logic [4:0]                idx;
    logic [23:0]               arg;
    logic [2:0]                rx_left;
    logic [2:0]                tx_left;
    logic [39:0]               tx_buf;
    logic [15:0]               tmo;
    logic [31:0]               addr;
    logic [AXI_DW-1:0]         wdata;
    logic                      arvalid, awvalid, wvalid, rready, bready;
    logic [32*GPIO_BANKS-1:0]  gpo_r;

    logic [2:0]  hdr_op;
    logic [4:0]  hdr_idx;
    logic        hdr_bad, idx_bad;
    logic [31:0] gpi_word, gpo_word, arg_next, rdata_al;
    logic [7:0]  id_byte;
    logic        aw_ok, w_ok;

    assign hdr_op   = rx_data[7:5];
    assign hdr_idx  = rx_data[4:0];
    assign hdr_bad  = 32'(hdr_idx) >= GPIO_BANKS;
    assign idx_bad  = 32'(idx) >= GPIO_BANKS;
    assign arg_next = {arg, rx_data};
    assign id_byte  = {3'(GPIO_BANKS - 1), 2'(LNB), 3'b101};
    // Read data sits MSB-aligned so the shift buffer emits exactly NB bytes after status
    assign rdata_al = 32'(m_axi_rdata) << (32 - AXI_DW);
    // A channel counts as done once its valid has dropped or it handshakes this cycle
    assign aw_ok    = !awvalid || m_axi_awready;
    assign w_ok     = !wvalid || m_axi_wready;

    always_comb begin
        gpi_word = '0;
        gpo_word = '0;
        for (int k = 0; k < GPIO_BANKS; k++) begin
            if (hdr_idx == 5'(k)) begin
                gpi_word = gpi[32*k +: 32];
                gpo_word = gpo_r[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op      <= '0;
            idx     <= '0;
            arg     <= '0;
            rx_left <= '0;
            tx_left <= '0;
            tx_buf  <= '0;
            tmo     <= '0;
            addr    <= AXI_ADDR_ON_RESET;
            wdata   <= '0;
            arvalid <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            rready  <= 1'b0;
            bready  <= 1'b0;
            gpo_r   <= GPO_ON_RESET;
        end else begin
            case (state)
                IDLE: if (rx_valid) begin
                    op  <= hdr_op;
                    idx <= hdr_idx;
                    arg <= '0;
                    case (hdr_op)
                        3'd1, 3'd2: begin
                            if (hdr_bad) begin
                                tx_buf  <= {8'h80, 32'h0};
                                tx_left <= 3'd1;
                            end else begin
                                tx_buf  <= {(hdr_op == 3'd1) ? gpi_word : gpo_word, 8'h0};
                                tx_left <= 3'd4;
                            end
                            state <= TX;
                        end
                        3'd3, 3'd4: begin
                            rx_left <= 3'd4;
                            state   <= RX_ARG;
                        end
                        3'd5: begin
                            arvalid <= 1'b1;
                            tmo     <= '0;
                            state   <= AXI_AR;
                        end
                        3'd6: begin
                            rx_left <= 3'(NB);
                            state   <= RX_ARG;
                        end
                        3'd7: begin
                            tx_buf  <= {id_byte, 32'h0};
                            tx_left <= 3'd1;
                            state   <= TX;
                        end
                        default: ;
                    endcase
                end
                RX_ARG: if (rx_valid) begin
                    arg     <= arg_next[23:0];
                    rx_left <= rx_left - 3'd1;
                    if (rx_left == 3'd1) begin
                        case (op)
                            3'd3: begin
                                // Whole word lands in one cycle; a bad index just drains the bytes
                                for (int k = 0; k < GPIO_BANKS; k++)
                                    if (idx == 5'(k)) gpo_r[32*k +: 32] <= arg_next;
                                tx_buf  <= {idx_bad ? 8'h80 : 8'h00, 32'h0};
                                tx_left <= 3'd1;
                                state   <= TX;
                            end
                            3'd4: begin
                                addr    <= arg_next;
                                tx_buf  <= '0;
                                tx_left <= 3'd1;
                                state   <= TX;
                            end
                            default: begin
                                wdata   <= arg_next[AXI_DW-1:0];
                                awvalid <= 1'b1;
                                wvalid  <= 1'b1;
                                tmo     <= '0;
                                state   <= AXI_AWW;
                            end
                        endcase
                    end
                end
                AXI_AR: begin
                    if (m_axi_arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        tmo     <= '0;
                        state   <= AXI_R;
                    end else if (tmo == TO_LAST) begin
                        arvalid <= 1'b0;
                        tx_buf  <= {8'h04, 32'h0};
                        tx_left <= 3'(1 + NB);
                        state   <= TX;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                AXI_R: begin
                    if (m_axi_rvalid) begin
                        rready  <= 1'b0;
                        tx_buf  <= {6'b0, m_axi_rresp, rdata_al};
                        tx_left <= 3'(1 + NB);
                        if (idx[0]) addr <= addr + 32'(NB);
                        state   <= TX;
                    end else if (tmo == TO_LAST) begin
                        rready  <= 1'b0;
                        tx_buf  <= {8'h04, 32'h0};
                        tx_left <= 3'(1 + NB);
                        state   <= TX;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                AXI_AWW: begin
                    if (aw_ok && w_ok) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        bready  <= 1'b1;
                        tmo     <= '0;
                        state   <= AXI_B;
                    end else if (tmo == TO_LAST) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        tx_buf  <= {8'h04, 32'h0};
                        tx_left <= 3'd1;
                        state   <= TX;
                    end else begin
                        if (m_axi_awready) awvalid <= 1'b0;
                        if (m_axi_wready)  wvalid  <= 1'b0;
                        tmo <= tmo + 16'd1;
                    end
                end
                AXI_B: begin
                    if (m_axi_bvalid) begin
                        bready  <= 1'b0;
                        tx_buf  <= {6'b0, m_axi_bresp, 32'h0};
                        tx_left <= 3'd1;
                        if (idx[0]) addr <= addr + 32'(NB);
                        state   <= TX;
                    end else if (tmo == TO_LAST) begin
                        bready  <= 1'b0;
                        tx_buf  <= {8'h04, 32'h0};
                        tx_left <= 3'd1;
                        state   <= TX;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                TX: if (tx_ready) begin
                    tx_buf  <= tx_buf << 8;
                    tx_left <= tx_left - 3'd1;
                    if (tx_left == 3'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_ready      = (state == IDLE) || (state == RX_ARG);
    assign tx_valid      = (state == TX);
    assign tx_data       = tx_buf[39:32];
    assign gpo           = gpo_r;
    assign m_axi_araddr  = addr;
    assign m_axi_awaddr  = addr;
    assign m_axi_arsize  = 3'(LNB);
    assign m_axi_awsize  = 3'(LNB);
    assign m_axi_arvalid = arvalid;
    assign m_axi_rready  = rready;
    assign m_axi_awvalid = awvalid;
    assign m_axi_wvalid  = wvalid;
    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = bready;
endmodule

// File: tb/tb_uartprobe_ng.sv
// tb/tb_uartprobe_ng.sv - directed bench for uartprobe_ng with a command-level response model
module tb_uartprobe_ng;
    localparam logic [63:0] GPO_RST = 64'h0000_0001_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic [63:0] gpo, gpi;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;

    uartprobe_ng #(
        .GPIO_BANKS(2), .AXI_DW(32), .GPO_ON_RESET(GPO_RST),
        .AXI_ADDR_ON_RESET(32'h0), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .gpo(gpo), .gpi(gpi),
        .m_axi_araddr(araddr), .m_axi_arsize(arsize), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awsize(awsize), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [63:0] gpo_m;
    logic [31:0] addr_m, wdata_m;
    int          cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event never came", name);
    endtask

    task automatic exp_byte(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    // Model of a bank read: out-of-range index answers with a lone bad-index status
    task automatic model_rd(input logic [63:0] banks, input int idx);
        if (idx >= 2) exp_byte(8'h80);
        else exp_word(banks[32*idx +: 32]);
    endtask

    // Compare process: response bytes in order, GPO state, AXI address/data and valid release
    logic prev_ar_hs = 1'b0, prev_aw_hs = 1'b0, prev_w_hs = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("gpo", gpo, gpo_m);
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got %h, required no byte", tx_data);
                end else begin
                    chk("tx_data", 64'(tx_data), 64'(exp_q[0]));
                    if (tx_ready) void'(exp_q.pop_front());
                end
            end
            if (arvalid) begin
                chk("araddr", 64'(araddr), 64'(addr_m));
                chk("arsize", 64'(arsize), 64'd2);
            end
            if (awvalid) begin
                chk("awaddr", 64'(awaddr), 64'(addr_m));
                chk("awsize", 64'(awsize), 64'd2);
            end
            if (wvalid) begin
                chk("wdata", 64'(wdata), 64'(wdata_m));
                chk("wstrb", 64'(wstrb), 64'hF);
            end
            if (prev_ar_hs) chk("arvalid_release", 64'(arvalid), 64'd0);
            if (prev_aw_hs) chk("awvalid_release", 64'(awvalid), 64'd0);
            if (prev_w_hs)  chk("wvalid_release", 64'(wvalid), 64'd0);
            prev_ar_hs = arvalid && arready;
            prev_aw_hs = awvalid && awready;
            prev_w_hs  = wvalid && wready;
        end else begin
            prev_ar_hs = 1'b0;
            prev_aw_hs = 1'b0;
            prev_w_hs  = 1'b0;
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tx_ready = (cyc % 3) != 0;
        end
    end

    task automatic send(input logic [7:0] b);
        logic r;
        int   n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                fail_msg("rx_accept");
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tx_drain: got %0d bytes pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input string name, input int which, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if ((which == 0 && arvalid) || (which == 1 && awvalid)) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) fail_msg(name);
    endtask

    task automatic read_slave(input int ar_delay, input logic [31:0] data, input logic [1:0] resp);
        logic ok, r;
        int   n;
        wait_neg("arvalid_start", 0, ok);
        if (ok) begin
            repeat (ar_delay) begin
                @(posedge clk);
                #1;
            end
            arready = 1'b1;
            @(posedge clk);
            #1;
            arready = 1'b0;
            rvalid  = 1'b1;
            rdata   = data;
            rresp   = resp;
            n = 0;
            forever begin
                @(negedge clk);
                r = rready;
                @(posedge clk);
                #1;
                if (r) break;
                n++;
                if (n > 100) begin
                    fail_msg("rready");
                    break;
                end
            end
            rvalid = 1'b0;
        end
    endtask

    task automatic write_slave(input int aw_d, input int w_d, input logic [1:0] resp);
        logic ok, r;
        int   n;
        wait_neg("awvalid_start", 1, ok);
        if (ok) begin
            for (int c = 0; c <= ((aw_d > w_d) ? aw_d : w_d); c++) begin
                awready = (c == aw_d);
                wready  = (c == w_d);
                @(posedge clk);
                #1;
            end
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b1;
            bresp   = resp;
            n = 0;
            forever begin
                @(negedge clk);
                r = bready;
                @(posedge clk);
                #1;
                if (r) break;
                n++;
                if (n > 100) begin
                    fail_msg("bready");
                    break;
                end
            end
            bvalid = 1'b0;
        end
    endtask

    task automatic count_ar(output int cnt);
        logic ok;
        cnt = 0;
        wait_neg("arvalid_start", 0, ok);
        if (ok) begin
            cnt = 1;
            while (cnt < 100) begin
                @(negedge clk);
                if (!arvalid) break;
                cnt++;
            end
        end
    endtask

    initial begin
        int ar_cycles;
        reset = 1'b1;
        rx_valid = 1'b0; rx_data = '0;
        gpi = 64'h89AB_CDEF_0123_4567;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        gpo_m = GPO_RST; addr_m = 32'h0; wdata_m = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        chk("rst_gpo", gpo, 64'h0000_0001_DEAD_BEEF);
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        exp_word(32'h0000_0001); send(8'h41); wait_tx();
        exp_word(32'hDEAD_BEEF); send(8'h40); wait_tx();
        model_rd(gpi, 1); send(8'h21); wait_tx();
        model_rd(gpi, 0); send(8'h20); wait_tx();
        model_rd(gpi, 5); send(8'h25); wait_tx();
        model_rd(gpo_m, 2); send(8'h42); wait_tx();
        send(8'h00); wait_tx();

        exp_byte(8'h00);
        send(8'h60); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        gpo_m[31:0] = 32'h1234_5678;
        chk("gpo_wr_literal", 64'(gpo[31:0]), 64'h1234_5678);
        wait_tx();
        exp_byte(8'h80);
        send(8'h62); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_tx();
        model_rd(gpo_m, 0); send(8'h40); wait_tx();

        exp_byte(8'h00);
        send(8'h80); send(8'h00); send(8'h00); send(8'h10); send(8'h00);
        addr_m = 32'h1000;
        wait_tx();

        exp_byte(8'h00); exp_word(32'hCAFE_F00D);
        fork
            send(8'hA1);
            read_slave(3, 32'hCAFE_F00D, 2'b00);
        join
        wait_tx();
        addr_m = 32'h1004;

        exp_byte(8'h03); exp_word(32'h5566_7788);
        fork
            send(8'hA0);
            read_slave(0, 32'h5566_7788, 2'b11);
        join
        wait_tx();

        wdata_m = 32'hA55A_00FF;
        exp_byte(8'h02);
        fork
            begin
                send(8'hC0); send(8'hA5); send(8'h5A); send(8'h00); send(8'hFF);
            end
            write_slave(1, 4, 2'b10);
        join
        wait_tx();

        wdata_m = 32'h0102_0304;
        exp_byte(8'h00);
        fork
            begin
                send(8'hC1); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
            end
            write_slave(0, 0, 2'b00);
        join
        wait_tx();
        addr_m = 32'h1008;

        exp_byte(8'h04); exp_word(32'h0);
        fork
            send(8'hA1);
            count_ar(ar_cycles);
        join
        chk("timeout_ar_cycles", 64'(ar_cycles), 64'd16);
        wait_tx();

        exp_byte(8'h01); exp_word(32'h1122_3344);
        fork
            send(8'hA0);
            read_slave(1, 32'h1122_3344, 2'b01);
        join
        wait_tx();

        send(8'hC0); send(8'hA5); send(8'h5A);
        reset = 1'b1;
        @(posedge clk);
        #1;
        gpo_m = GPO_RST;
        addr_m = 32'h0;
        @(negedge clk);
        chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
        chk("midrst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_byte(8'h35);
        send(8'hE0);
        wait_tx();
        model_rd(gpo_m, 0); send(8'h40); wait_tx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
